// File: rtl/ip_codma_pkg.sv
// codma memory-bus shared types: bus bundle, size codes,
// responder state encoding and size decode helpers.
package ip_codma_pkg;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [3:0]  size;
    logic        write_valid;
    logic [63:0] write_data;
    logic        grant;
    logic        read_valid;
    logic [63:0] read_data;
    logic        error;
    logic        busy;
  } mem_interface_t;

  localparam logic [3:0] SZ_1B   = 4'd0;
  localparam logic [3:0] SZ_2B   = 4'd1;
  localparam logic [3:0] SZ_4B   = 4'd2;
  localparam logic [3:0] SZ_8B   = 4'd3;
  localparam logic [3:0] SZ_16B  = 4'd4;
  localparam logic [3:0] SZ_32B  = 4'd5;
  localparam logic [3:0] SZ_IDLE = 4'd9;

  typedef logic [1:0] resp_state_t;

  localparam resp_state_t RESP_IDLE = 2'd0;
  localparam resp_state_t RESP_WAIT = 2'd1;
  localparam resp_state_t RESP_RD   = 2'd2;
  localparam resp_state_t RESP_WR   = 2'd3;

  function automatic logic [2:0] size_beats(
    input logic [3:0] s
  );
    if (s == SZ_16B) return 3'd2;
    if (s == SZ_32B) return 3'd4;
    return 3'd1;
  endfunction

  function automatic logic [6:0] size_bytes(
    input logic [3:0] s
  );
    if (s > SZ_32B) return 7'd0;
    return 7'd1 << s[2:0];
  endfunction

endpackage

// File: rtl/ip_codma_mem_array.sv
// DEPTH x 64-bit word store: byte-enabled synchronous write,
// combinational read, contents survive reset.
module ip_codma_mem_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [7:0]    be_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [63:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [63:0]   rdata_o
);

  logic [63:0] mem_q [DEPTH];

  // byte-lane write of the addressed word
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 8; b++) begin
        if (be_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ip_codma_mem_responder.sv
// codma bus target: request check, delayed grant, burst
// read streaming and write absorption into the word array.
module ip_codma_mem_responder
  import ip_codma_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned GRANT_DELAY = 2,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        bus_read_i,
  input  logic        bus_write_i,
  input  logic [31:0] bus_addr_i,
  input  logic [3:0]  bus_size_i,
  input  logic        bus_write_valid_i,
  input  logic [63:0] bus_write_data_i,
  output logic        bus_grant_o,
  output logic        bus_read_valid_o,
  output logic [63:0] bus_read_data_o,
  output logic        bus_error_o,
  output logic        bus_busy_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = 33'(DEPTH) << 3;

  resp_state_t   state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [2:0]    beats_q, beats_d;
  logic [2:0]    beat_q, beat_d;
  logic [7:0]    mask_q, mask_d;
  logic          dir_q, dir_d;
  logic [15:0]   dly_q, dly_d;
  logic [15:0]   idle_q, idle_d;
  logic          grant_q, grant_d;
  logic          rvalid_q, rvalid_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          error_q, error_d;

  logic [32:0]   off;
  logic [32:0]   end_off;
  logic [6:0]    nbytes;
  logic [2:0]    nbeats;
  logic [7:0]    lmask;
  logic          aligned;
  logic          legal;
  logic          we;
  logic [AW-1:0] word_a;
  logic [63:0]   rd_word;

  // request legality: size code, natural alignment, range
  always_comb begin
    nbytes  = size_bytes(bus_size_i);
    nbeats  = size_beats(bus_size_i);
    off     = {1'b0, bus_addr_i} - {1'b0, BASE_ADDR};
    end_off = {1'b0, off[31:0]} + 33'(nbytes);
    aligned = 1'b1;
    if (bus_size_i == SZ_2B) aligned = !bus_addr_i[0];
    if (bus_size_i == SZ_4B) aligned = bus_addr_i[1:0] == 2'd0;
    if (bus_size_i >= SZ_8B) aligned = bus_addr_i[2:0] == 3'd0;
    legal = (bus_size_i <= SZ_32B) && aligned
         && !off[32] && (end_off <= LIMIT);
    lmask = 8'hFF;
    if (bus_size_i < SZ_8B) begin
      lmask = ((8'd1 << nbytes[2:0]) - 8'd1) << off[2:0];
    end
  end

  // responder state machine
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    beats_d  = beats_q;
    beat_d   = beat_q;
    mask_d   = mask_q;
    dir_d    = dir_q;
    dly_d    = dly_q;
    idle_d   = idle_q;
    grant_d  = 1'b0;
    rvalid_d = 1'b0;
    rdata_d  = 64'd0;
    error_d  = 1'b0;
    we       = 1'b0;
    unique case (state_q)
      RESP_IDLE: begin
        if (bus_read_i || bus_write_i) begin
          if (legal) begin
            state_d = RESP_WAIT;
            idx_d   = off[AW+2:3];
            beats_d = nbeats;
            beat_d  = 3'd0;
            dir_d   = bus_read_i;
            mask_d  = bus_read_i ? 8'hFF : lmask;
            dly_d   = 16'(GRANT_DELAY - 1);
          end else begin
            error_d = 1'b1;
          end
        end
      end
      RESP_WAIT: begin
        if (dly_q == 16'd0) begin
          grant_d = 1'b1;
          state_d = dir_q ? RESP_RD : RESP_WR;
          idle_d  = 16'd0;
          beat_d  = 3'd0;
        end else begin
          dly_d = dly_q - 16'd1;
        end
      end
      RESP_RD: begin
        if (beat_q != beats_q) begin
          rvalid_d = 1'b1;
          rdata_d  = rd_word;
          beat_d   = beat_q + 3'd1;
        end else begin
          state_d = RESP_IDLE;
        end
      end
      RESP_WR: begin
        // a beat presented alongside grant is not taken
        if (!grant_q) begin
          if (bus_write_valid_i) begin
            we     = 1'b1;
            beat_d = beat_q + 3'd1;
            idle_d = 16'd0;
            if (beat_q + 3'd1 == beats_q) state_d = RESP_IDLE;
          end else if (idle_q == 16'(TIMEOUT - 1)) begin
            error_d = 1'b1;
            state_d = RESP_IDLE;
          end else begin
            idle_d = idle_q + 16'd1;
          end
        end
      end
      default: state_d = RESP_IDLE;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= RESP_IDLE;
      idx_q    <= '0;
      beats_q  <= 3'd0;
      beat_q   <= 3'd0;
      mask_q   <= 8'd0;
      dir_q    <= 1'b0;
      dly_q    <= 16'd0;
      idle_q   <= 16'd0;
      grant_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 64'd0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      beats_q  <= beats_d;
      beat_q   <= beat_d;
      mask_q   <= mask_d;
      dir_q    <= dir_d;
      dly_q    <= dly_d;
      idle_q   <= idle_d;
      grant_q  <= grant_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
    end
  end

  assign word_a = idx_q + AW'(beat_q);

  ip_codma_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (we),
    .be_i    (mask_q),
    .waddr_i (word_a),
    .wdata_i (bus_write_data_i),
    .raddr_i (word_a),
    .rdata_o (rd_word)
  );

  assign bus_grant_o      = grant_q;
  assign bus_read_valid_o = rvalid_q;
  assign bus_read_data_o  = rdata_q;
  assign bus_error_o      = error_q;
  assign bus_busy_o       = state_q != RESP_IDLE;

endmodule

// File: tb/tb_ip_codma_mem_responder.sv
// Bench for ip_codma_mem_responder: vector table, corner
// sequences and random traffic against a word-array model.
module tb_ip_codma_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0;
  localparam int unsigned GD    = 2;
  localparam int unsigned TO    = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bread, bwrite, bwv;
  logic [31:0] baddr;
  logic [3:0]  bsize;
  logic [63:0] bwd;
  logic        bgrant, brv, berr, bbusy;
  logic [63:0] brd;

  always #5 clk = ~clk;

  ip_codma_mem_responder #(
    .DEPTH       (DEPTH),
    .BASE_ADDR   (BASE),
    .GRANT_DELAY (GD),
    .TIMEOUT     (TO)
  ) dut (
    .clk_i             (clk),
    .reset_n_i         (rst_n),
    .bus_read_i        (bread),
    .bus_write_i       (bwrite),
    .bus_addr_i        (baddr),
    .bus_size_i        (bsize),
    .bus_write_valid_i (bwv),
    .bus_write_data_i  (bwd),
    .bus_grant_o       (bgrant),
    .bus_read_valid_o  (brv),
    .bus_read_data_o   (brd),
    .bus_error_o       (berr),
    .bus_busy_o        (bbusy)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] mdl [DEPTH];
  logic [63:0] wbuf [4];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [3:0]  s;
    logic        err;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [3:0] s);
    return 1 << s;
  endfunction

  function automatic int nbeats(input logic [3:0] s);
    return (nbytes(s) <= 8) ? 1 : nbytes(s) / 8;
  endfunction

  function automatic bit legal(input logic [31:0] a,
                               input logic [3:0] s);
    longint unsigned nb, al, off;
    if (s > 4'd5) return 1'b0;
    nb = 64'd1 << s;
    al = (nb > 8) ? 8 : nb;
    if ((64'(a) % al) != 0) return 1'b0;
    if (a < BASE) return 1'b0;
    off = 64'(a - BASE);
    return (off + nb) <= 64'(DEPTH) * 8;
  endfunction

  task automatic req(input logic rd, input logic wr,
                     input logic [31:0] a, input logic [3:0] s);
    bread = rd; bwrite = wr; baddr = a; bsize = s;
    @(posedge clk); #1;
    bread = 1'b0; bwrite = 1'b0; bsize = 4'd9;
  endtask

  task automatic wait_grant(input string nm);
    for (int k = 0; k < int'(GD); k++) begin
      chk({nm, " wait"}, {62'd0, bgrant, bbusy}, 64'd1);
      @(posedge clk); #1;
    end
    chk({nm, " grant"}, {62'd0, bgrant, bbusy}, 64'd3);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] s,
                         input logic wr, input string nm);
    int w;
    w = int'((a - BASE) >> 3);
    req(1'b1, wr, a, s);
    wait_grant(nm);
    for (int b = 0; b < nbeats(s); b++) begin
      @(posedge clk); #1;
      chk($sformatf("%s valid%0d", nm, b), 64'(brv), 64'd1);
      chk($sformatf("%s data%0d", nm, b), brd, mdl[w+b]);
    end
    @(posedge clk); #1;
    chk({nm, " end"}, {62'd0, brv, bbusy}, 64'd0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] s,
                          input string nm);
    int w, lo;
    w  = int'((a - BASE) >> 3);
    lo = int'((a - BASE) % 8);
    req(1'b0, 1'b1, a, s);
    wait_grant(nm);
    bwv = 1'b1;
    bwd = ~wbuf[0];
    for (int b = 0; b < nbeats(s); b++) begin
      @(posedge clk); #1;
      bwd = wbuf[b];
    end
    @(posedge clk); #1;
    bwv = 1'b0;
    chk({nm, " end"}, 64'(bbusy), 64'd0);
    if (s <= 4'd2) begin
      for (int l = 0; l < 8; l++) begin
        if (l >= lo && l < lo + nbytes(s))
          mdl[w][l*8 +: 8] = wbuf[0][l*8 +: 8];
      end
    end else begin
      for (int b = 0; b < nbeats(s); b++) mdl[w+b] = wbuf[b];
    end
  endtask

  task automatic do_illegal(input logic rd, input logic wr,
                            input logic [31:0] a, input logic [3:0] s,
                            input string nm);
    req(rd, wr, a, s);
    chk({nm, " err"}, {61'd0, berr, bgrant, bbusy}, 64'd4);
    @(posedge clk); #1;
    chk({nm, " after"}, {61'd0, berr, bgrant, bbusy}, 64'd0);
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k;
    logic [31:0] a;
    logic [3:0]  s;
    int al, op;

    rst_n = 1'b0; bread = 1'b0; bwrite = 1'b0; bwv = 1'b0;
    baddr = 32'd0; bsize = 4'd9; bwd = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outs", {60'd0, bgrant, brv, berr, bbusy}, 64'd0);
    chk("reset data", brd, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // burst write then burst read at 0x40
    wbuf[0] = 64'h1111_1111_1111_1111;
    wbuf[1] = 64'h2222_2222_2222_2222;
    wbuf[2] = 64'h3333_3333_3333_3333;
    wbuf[3] = 64'h4444_4444_4444_4444;
    do_write(32'h40, 4'd5, "wr32");
    do_read(32'h40, 4'd5, 1'b0, "rd32");

    // single byte lane 3 write
    wbuf[0] = 64'h0000_0000_AB00_0000;
    do_write(32'h43, 4'd0, "wr1b");
    do_read(32'h40, 4'd3, 1'b0, "rd1b");

    // read and write together: read wins, memory untouched
    wbuf[0] = 64'hC0FF_EE00_1234_5678;
    do_write(32'h80, 4'd3, "pre_both");
    bwv = 1'b1;
    bwd = 64'hDEAD_BEEF_DEAD_BEEF;
    do_read(32'h80, 4'd3, 1'b1, "both");
    bwv = 1'b0;
    do_read(32'h80, 4'd3, 1'b0, "both_chk");

    // vector table
    vt[0]  = '{1'b1, 1'b0, 32'h44, 4'd3, 1'b1};
    vt[1]  = '{1'b1, 1'b0, 32'h40, 4'd7, 1'b1};
    vt[2]  = '{1'b1, 1'b0, DEPTH * 8, 4'd0, 1'b1};
    vt[3]  = '{1'b1, 1'b0, 32'h41, 4'd1, 1'b1};
    vt[4]  = '{1'b1, 1'b0, 32'h42, 4'd1, 1'b0};
    vt[5]  = '{1'b0, 1'b1, DEPTH * 8 - 8, 4'd3, 1'b0};
    vt[6]  = '{1'b1, 1'b0, DEPTH * 8 - 8, 4'd3, 1'b0};
    vt[7]  = '{1'b1, 1'b0, DEPTH * 8 - 16, 4'd5, 1'b1};
    vt[8]  = '{1'b0, 1'b1, 32'h46, 4'd2, 1'b1};
    vt[9]  = '{1'b0, 1'b1, 32'h44, 4'd2, 1'b0};
    vt[10] = '{1'b1, 1'b0, 32'h40, 4'd9, 1'b1};
    vt[11] = '{1'b1, 1'b0, 32'h48, 4'd4, 1'b0};
    for (int i = 0; i < 12; i++) begin
      if (vt[i].err) begin
        do_illegal(vt[i].rd, vt[i].wr, vt[i].a, vt[i].s,
                   $sformatf("vec%0d", i));
      end else if (vt[i].rd) begin
        do_read(vt[i].a, vt[i].s, 1'b0, $sformatf("vec%0d", i));
      end else begin
        for (int b = 0; b < 4; b++) wbuf[b] = r64();
        do_write(vt[i].a, vt[i].s, $sformatf("vec%0d", i));
      end
    end

    // write stall timeout after first of two beats
    wbuf[0] = 64'hA0A0_A0A0_A0A0_A0A0;
    wbuf[1] = 64'hA1A1_A1A1_A1A1_A1A1;
    do_write(32'hA0, 4'd4, "pre_to");
    req(1'b0, 1'b1, 32'hA0, 4'd4);
    wait_grant("to");
    @(posedge clk); #1;
    bwv = 1'b1;
    bwd = 64'h5555_6666_7777_8888;
    @(posedge clk); #1;
    bwv = 1'b0;
    k = 0;
    while (!berr && k < int'(TO) + 4) begin
      @(posedge clk); #1;
      k++;
    end
    chk("to cycles", 64'(k), 64'(TO));
    chk("to busy", 64'(bbusy), 64'd0);
    mdl[20] = 64'h5555_6666_7777_8888;
    @(posedge clk); #1;
    chk("to pulse", 64'(berr), 64'd0);
    do_read(32'hA0, 4'd4, 1'b0, "to_rd");

    // reset during second read beat
    req(1'b1, 1'b0, 32'h40, 4'd5);
    wait_grant("rst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst beat1", brd, mdl[9]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst outs", {60'd0, bgrant, brv, berr, bbusy}, 64'd0);
    chk("rst data", brd, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(32'h40, 4'd5, 1'b0, "post_rst");

    // random traffic over words 0..15
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < 4; b++) wbuf[b] = r64();
      do_write(32'(i * 32), 4'd5, "fill");
    end
    for (int i = 0; i < 60; i++) begin
      s  = ($urandom_range(0, 9) == 9) ? 4'd9
                                       : 4'($urandom_range(0, 6));
      al = (s >= 4'd3) ? 8 : (1 << s);
      a  = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) a = a & ~32'(al - 1);
      op = int'($urandom_range(0, 2));
      if (!legal(a, s)) begin
        do_illegal(op != 1, op != 0, a, s, $sformatf("rnd%0d", i));
      end else if (op != 1) begin
        do_read(a, s, op == 2, $sformatf("rnd%0d", i));
      end else begin
        for (int b = 0; b < 4; b++) wbuf[b] = r64();
        do_write(a, s, $sformatf("rnd%0d", i));
      end
    end
    for (int i = 0; i < 4; i++)
      do_read(32'(i * 32), 4'd5, 1'b0, "final");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
